// File: rtl/led_bounce_decoder.sv
// Tracks a single lit LED bouncing between bit 0 and bit 7 and flags sequence faults.
// Define LED_BOUNCE_CNT_EN to build the end-bounce counter; otherwise bounce_cnt is tied to 0.
module led_bounce_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] IN,
  output logic [2:0] pos,
  output logic       dir,
  output logic       locked,
  output logic       err,
  output logic [7:0] bounce_cnt
);

  typedef enum logic [1:0] {StSearch, StAcquire, StTrack, StFault} state_e;

  state_e     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic       dir_q, dir_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;

  logic       valid;
  logic [2:0] idx;
  logic [3:0] idx_w, pos_w;
  logic       step_up, step_dn, step_ok, hold;

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (IN[i]) idx = i[2:0];
    end
  end

  // 4-bit compares so that pos 7 + 1 and pos 0 - 1 never alias onto a real index
  assign valid   = $onehot(IN);
  assign idx_w   = {1'b0, idx};
  assign pos_w   = {1'b0, pos_q};
  assign step_up = valid && (idx_w == pos_w + 4'd1);
  assign step_dn = valid && (idx_w + 4'd1 == pos_w);
  assign step_ok = dir_q ? step_up : step_dn;
  assign hold    = (IN == (8'd1 << pos_q));

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    err_d    = err_q;
    if (clr) begin
      state_d  = StSearch;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else if (en) begin
      unique case (state_q)
        StSearch: begin
          if (valid) begin
            pos_d   = idx;
            state_d = StAcquire;
          end
        end
        StAcquire: begin
          if (step_up) begin
            pos_d    = idx;
            dir_d    = (idx != 3'd7);
            state_d  = StTrack;
            locked_d = 1'b1;
          end else if (step_dn) begin
            pos_d    = idx;
            dir_d    = (idx == 3'd0);
            state_d  = StTrack;
            locked_d = 1'b1;
          end else if (valid) begin
            pos_d = idx;
          end else begin
            state_d = StSearch;
          end
        end
        StTrack: begin
          if (hold) begin
            state_d = StTrack;
          end else if (step_ok) begin
            pos_d = idx;
            if (idx == 3'd7) dir_d = 1'b0;
            else if (idx == 3'd0) dir_d = 1'b1;
          end else begin
            state_d  = StFault;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        StFault: begin
          state_d = StFault;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StSearch;
      pos_q    <= 3'd0;
      dir_q    <= 1'b1;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign pos    = pos_q;
  assign dir    = dir_q;
  assign locked = locked_q;
  assign err    = err_q;

`ifdef LED_BOUNCE_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       bounce;

  assign bounce = en && (state_q == StTrack) && !hold && step_ok && (idx == 3'd7 || idx == 3'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (bounce && cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bounce_cnt = cnt_q;
`else
  assign bounce_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_led_bounce_decoder.sv
// Scoreboard bench for led_bounce_decoder: directed scenarios plus a random phase,
// all checked against a behavioural model of the LED-bounce rules.
module tb_led_bounce_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] IN = 8'h00;
  logic [2:0] pos;
  logic       dir, locked, err;
  logic [7:0] bounce_cnt;

  led_bounce_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .IN         (IN),
    .pos        (pos),
    .dir        (dir),
    .locked     (locked),
    .err        (err),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pos;
    logic       dir;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: 0 search, 1 acquire, 2 track, 3 fault
  int m_st = 0, m_pos = 0, m_dir = 1, m_cnt = 0;

  task automatic bump();
`ifdef LED_BOUNCE_CNT_EN
    if (m_cnt < 255) m_cnt++;
`endif
  endtask

  task automatic model_step(input logic r, input logic c, input logic e, input logic [7:0] in);
    bit v;
    int k;
    v = ($countones(in) == 1);
    k = v ? $clog2(in) : -100;
    if (r) begin
      m_st = 0; m_pos = 0; m_dir = 1; m_cnt = 0;
    end else if (c) begin
      m_st = 0; m_cnt = 0;
    end else if (e) begin
      case (m_st)
        0: if (v) begin m_pos = k; m_st = 1; end
        1: begin
          if (v && k == m_pos + 1) begin
            m_dir = (k == 7) ? 0 : 1; m_pos = k; m_st = 2;
          end else if (v && k == m_pos - 1) begin
            m_dir = (k == 0) ? 1 : 0; m_pos = k; m_st = 2;
          end else if (v) begin
            m_pos = k;
          end else begin
            m_st = 0;
          end
        end
        2: begin
          if (int'(in) == (1 << m_pos)) begin
            // producer stalled
          end else if (v && k == (m_dir ? m_pos + 1 : m_pos - 1)) begin
            m_pos = k;
            if (k == 7) begin m_dir = 0; bump(); end
            if (k == 0) begin m_dir = 1; bump(); end
          end else begin
            m_st = 3;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic c, input logic e, input logic [7:0] in);
    exp_t x;
    @(negedge clk);
    reset = r; clr = c; en = e; IN = in;
    model_step(r, c, e, in);
    x.pos = 3'(m_pos); x.dir = 1'(m_dir);
    x.locked = (m_st == 2); x.err = (m_st == 3); x.cnt = 8'(m_cnt);
    q.push_back(x);
  endtask

  // Monitor: every posedge with a pending expectation is compared #1 later
  initial begin
    exp_t x, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        got = {pos, dir, locked, err, bounce_cnt};
        checks++;
        if (got !== x) begin
          errors++;
          $display("FAIL outputs t=%0t got pos=%0d dir=%0b locked=%0b err=%0b cnt=%0d exp pos=%0d dir=%0b locked=%0b err=%0b cnt=%0d",
                   $time, got.pos, got.dir, got.locked, got.err, got.cnt,
                   x.pos, x.dir, x.locked, x.err, x.cnt);
        end
      end
    end
  end

  initial begin
    int p, d, bounces, sel, np;
    logic [7:0] in;

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);

    // Full sweep up then one step down
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(1 << i));
    step(0, 0, 1, 8'h40);
    // Walk down to 0 and back up to pos 3
    for (int i = 5; i >= 0; i--) step(0, 0, 1, 8'(1 << i));
    for (int i = 1; i <= 3; i++) step(0, 0, 1, 8'(1 << i));
    // Stalled producer, then resume
    repeat (5) step(0, 0, 1, 8'h08);
    step(0, 0, 1, 8'h10);

    // Relock at pos 3 dir 1, then wrong-direction fault
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h04);
    step(0, 0, 1, 8'h08);
    step(0, 0, 1, 8'h04);
    step(0, 0, 1, 8'h08);
    step(0, 0, 0, 8'h10);
    step(0, 1, 1, 8'h10);

    // Search/acquire corner cases
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h03);
    step(0, 0, 1, 8'h20);
    step(0, 0, 1, 8'h80);
    step(0, 0, 1, 8'h40);

    // Long bounce run to saturate the counter
    p = 6; d = 0; bounces = 0;
    while (bounces < 300) begin
      p = d ? p + 1 : p - 1;
      step(0, 0, 1, 8'(1 << p));
      if (p == 7) begin d = 0; bounces++; end
      if (p == 0) begin d = 1; bounces++; end
    end
    step(0, 0, 1, 8'(1 << p));

    // Reset mid-track beats clr and en
    step(1, 1, 1, 8'h10);

    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 1) begin
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
      end else if (sel < 5) begin
        step(0, 1, $urandom_range(0, 1), 8'($urandom));
      end else begin
        sel = $urandom_range(0, 9);
        np = m_dir ? m_pos + 1 : m_pos - 1;
        if (np < 0 || np > 7) np = m_pos;
        case (sel)
          6:       in = 8'(1 << m_pos);
          7:       in = 8'(1 << $urandom_range(0, 7));
          8:       in = 8'($urandom);
          default: in = 8'(1 << np);
        endcase
        step(0, 0, ($urandom_range(0, 3) != 0), in);
      end
    end
    step(0, 0, 0, 8'h00);

    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_bounce_decoder.md
LED_BOUNCE_DECODER -- requirements
Module: led_bounce_decoder

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous active-high reset.
REQ-004 Port en, input, 1 bit: sample strobe; IN is evaluated only in cycles with en=1.
REQ-005 Port clr, input, 1 bit: synchronous fault clear and return to search.
REQ-006 Port IN, input, 8 bits: observed bouncing-LED pattern, bit 0 = rightmost LED.
REQ-007 Port pos, output, 3 bits: index of the lit LED in the last accepted sample.
REQ-008 Port dir, output, 1 bit: 1 = moving toward bit 7, 0 = moving toward bit 0.
REQ-009 Port locked, output, 1 bit: 1 while in TRACK.
REQ-010 Port err, output, 1 bit: sticky sequence-fault flag.
REQ-011 Port bounce_cnt, output, 8 bits: number of end-bounces seen while locked.

Function
REQ-012 All outputs SHALL be registered; the response to a sample SHALL be visible the cycle after the en=1 edge.
REQ-013 IN SHALL be "valid" only when exactly one bit is set; idx SHALL be that bit's index.
REQ-014 The FSM SHALL have the states SEARCH, ACQUIRE, TRACK and FAULT; with en=0 and clr=0 the state and all outputs SHALL hold.
REQ-015 SEARCH: a valid sample SHALL load pos=idx and go to ACQUIRE; an invalid sample SHALL stay in SEARCH with no error.
REQ-016 ACQUIRE, idx=pos+1: dir SHALL become 1, or 0 if idx=7; pos SHALL become idx; the FSM SHALL go to TRACK.
REQ-017 ACQUIRE, idx=pos-1: dir SHALL become 0, or 1 if idx=0; pos SHALL become idx; the FSM SHALL go to TRACK.
REQ-018 ACQUIRE, valid but non-adjacent (including idx=pos): pos SHALL become idx and the FSM SHALL stay in ACQUIRE.
REQ-019 ACQUIRE, invalid sample: the FSM SHALL return to SEARCH.
REQ-020 TRACK: the expected index SHALL be pos+1 when dir=1 and pos-1 when dir=0.
REQ-021 TRACK, valid sample with idx equal to the expected index: pos SHALL become idx.
REQ-022 On that accepted step, if idx=7 then dir SHALL become 0 and the bounce counter SHALL increment; if idx=0 then dir SHALL become 1 and the bounce counter SHALL increment.
REQ-023 TRACK, IN equal to the current one-hot pattern (producer stalled): the sample SHALL be treated as a hold, with no change and no error.
REQ-024 TRACK, any other sample (invalid, zero, multi-hot, wrong direction, or a jump): the FSM SHALL go to FAULT with err=1 and locked=0; pos and dir SHALL keep their last accepted values.
REQ-025 FAULT SHALL be sticky: samples SHALL be ignored until clr or reset.
REQ-026 clr=1 (with reset=0) SHALL force SEARCH, err=0, locked=0 and bounce_cnt=0, and SHALL take priority over en in the same cycle.
REQ-027 bounce_cnt SHALL saturate at 255 and SHALL not wrap.

Reset
REQ-028 reset=1 SHALL set state=SEARCH, pos=0, dir=1, locked=0, err=0 and bounce_cnt=0.
REQ-029 reset SHALL take priority over clr and en.
REQ-030 Asserting reset in any state, including mid-track and FAULT, SHALL give the same reset result.

Configuration
REQ-031 The macro LED_BOUNCE_CNT_EN SHALL control the bounce counter.
REQ-032 With LED_BOUNCE_CNT_EN defined, the bounce counter SHALL operate as specified in REQ-022, REQ-026 and REQ-027.
REQ-033 Without LED_BOUNCE_CNT_EN, the counter register SHALL be absent, bounce_cnt SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification
REQ-034 After reset, en=1 with IN=01,02,04,...,80,40: the first cycle after 02 SHALL show locked=1 and dir=1; after 80, pos=7 and dir=0; after 40, pos=6 and err=0; bounce_cnt SHALL be 1 with the counter enabled, else 0.
REQ-035 While locked at pos=3 and dir=1, hold IN=08 with en=1 for 5 cycles, then apply 10: there SHALL be no error, and pos SHALL become 4.
REQ-036 While locked at pos=3 and dir=1, apply IN=04: err=1, locked=0, pos stays 3; a further IN=08 is ignored; clr=1 then SHALL give err=0 and SEARCH.
REQ-037 In SEARCH, apply IN=00, then 03, then 20, then 80, then 40: the FSM SHALL stay in SEARCH for 00 and 03, go to ACQUIRE on 20, stay in ACQUIRE on 80, and lock on 40 with dir=0.
REQ-038 Run a full bounce pattern for 300 end-bounces: bounce_cnt SHALL reach 255 and hold there.
REQ-039 Assert reset mid-track together with en=1 and clr=1: the next cycle SHALL show all reset values from REQ-028.
